// File: rtl/io_load_tracker_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_load_tracker_params : shared load-kind, entry-state and ring-entry types
// Revision: 1.0
// ----------------------------------------------------------------------------
package io_load_tracker_params;

   localparam int LOAD_KIND_WIDTH = 3;

   typedef enum logic [LOAD_KIND_WIDTH-1:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LWL = 3'd3,
      LWR = 3'd4
   } load_kind_t;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      PENDING = 2'd1,
      DONE    = 2'd2,
      DISCARD = 2'd3
   } entry_state_t;

   // kind is kept as raw bits so undefined encodings survive to the formatter
   typedef struct packed {
      entry_state_t                state;
      logic                        is_store;
      logic [LOAD_KIND_WIDTH-1:0]  kind;
      logic                        is_unsigned;
      logic [1:0]                  offset;
      logic [31:0]                 data;
   } tracker_entry_t;

endpackage
`default_nettype wire

// File: rtl/io_load_tracker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_load_tracker_if : issue, response, flush and write-back signals of the tracker
// Revision: 1.0
// ----------------------------------------------------------------------------
interface io_load_tracker_if
   import io_load_tracker_params::*;
#(
   parameter int DEPTH          = 4,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = $clog2(DEPTH + 1)
) ();

   logic                       req_valid;
   logic                       req_ready;
   logic                       req_is_store;
   logic [LOAD_KIND_WIDTH-1:0] req_load_kind;
   logic                       req_unsigned;
   logic [1:0]                 req_address_low;
   logic [REG_ADDR_WIDTH-1:0]  req_write_register;
   logic                       resp_valid;
   logic [31:0]                resp_data;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic [31:0]                out_data;
   logic [3:0]                 out_write_strobe;
   logic [REG_ADDR_WIDTH-1:0]  out_write_register;
   logic [COUNT_WIDTH-1:0]     outstanding_count;
   logic                       resp_unexpected;

   modport slave (
      input  req_valid, req_is_store, req_load_kind, req_unsigned,
             req_address_low, req_write_register, resp_valid, resp_data,
             flush, out_ready,
      output req_ready, out_valid, out_data, out_write_strobe,
             out_write_register, outstanding_count, resp_unexpected
   );

   modport master (
      output req_valid, req_is_store, req_load_kind, req_unsigned,
             req_address_low, req_write_register, resp_valid, resp_data,
             flush, out_ready,
      input  req_ready, out_valid, out_data, out_write_strobe,
             out_write_register, outstanding_count, resp_unexpected
   );

endinterface
`default_nettype wire

// File: rtl/io_load_tracker_formatter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_result_formatter : aligns/extends raw load data into a register result
// Revision: 1.0
// ----------------------------------------------------------------------------
module load_result_formatter
   import io_load_tracker_params::*;
(
   input  logic [LOAD_KIND_WIDTH-1:0] i_kind,
   input  logic                       i_unsigned,
   input  logic [1:0]                 i_offset,
   input  logic [31:0]                i_data,
   output logic [31:0]                o_result,
   output logic [3:0]                 o_strobe
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_offset)
         2'd0: w_byte = i_data[7:0];
         2'd1: w_byte = i_data[15:8];
         2'd2: w_byte = i_data[23:16];
         2'd3: w_byte = i_data[31:24];
      endcase
      w_half   = i_offset[1] ? i_data[31:16] : i_data[15:0];
      o_result = i_data;
      o_strobe = 4'b1111;
      case (i_kind)
         LB: o_result = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         LH: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
         LWL: begin
            case (i_offset)
               2'd0: begin o_result = {i_data[7:0],  24'h0}; o_strobe = 4'b1000; end
               2'd1: begin o_result = {i_data[15:0], 16'h0}; o_strobe = 4'b1100; end
               2'd2: begin o_result = {i_data[23:0],  8'h0}; o_strobe = 4'b1110; end
               2'd3: begin o_result = i_data;                o_strobe = 4'b1111; end
            endcase
         end
         LWR: begin
            case (i_offset)
               2'd0: begin o_result = i_data;                  o_strobe = 4'b1111; end
               2'd1: begin o_result = {8'h0,  i_data[31:8]};   o_strobe = 4'b0111; end
               2'd2: begin o_result = {16'h0, i_data[31:16]};  o_strobe = 4'b0011; end
               2'd3: begin o_result = {24'h0, i_data[31:24]};  o_strobe = 4'b0001; end
            endcase
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/io_load_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_load_tracker : in-order ring of outstanding data-bus transactions feeding wb
// Revision: 1.0
// ----------------------------------------------------------------------------
module io_load_tracker
   import io_load_tracker_params::*;
#(
   parameter int DEPTH          = 4,
   parameter int COUNT_WIDTH    = $clog2(DEPTH + 1),
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic             clock,
   input  logic             reset,
   io_load_tracker_if.slave bus
);

   localparam int PTR_WIDTH = $clog2(DEPTH);

   tracker_entry_t            r_ent  [DEPTH];
   logic [REG_ADDR_WIDTH-1:0] r_wreg [DEPTH];
   logic [PTR_WIDTH-1:0]      r_tail;
   logic [PTR_WIDTH-1:0]      r_resp_ptr;
   logic [PTR_WIDTH-1:0]      r_head;
   logic [COUNT_WIDTH-1:0]    r_count;
   logic                      r_resp_unexpected;

   tracker_entry_t            w_head;
   logic                      w_ready;
   logic                      w_alloc;
   logic                      w_resp_pend;
   logic                      w_resp_disc;
   logic                      w_resp_live;
   logic                      w_head_done;
   logic                      w_retire;
   logic [PTR_WIDTH-1:0]      w_resp_ptr_nxt;
   logic [COUNT_WIDTH-1:0]    w_done_cnt;

   assign w_head         = r_ent[r_head];
   assign w_ready        = (r_count != COUNT_WIDTH'(DEPTH)) && !bus.flush;
   assign w_alloc        = bus.req_valid && w_ready;
   assign w_resp_pend    = bus.resp_valid && (r_ent[r_resp_ptr].state == PENDING);
   assign w_resp_disc    = bus.resp_valid && (r_ent[r_resp_ptr].state == DISCARD);
   assign w_resp_live    = w_resp_pend || w_resp_disc;
   assign w_head_done    = !bus.flush && (w_head.state == DONE);
   assign w_retire       = w_head_done && (w_head.is_store || bus.out_ready);
   assign w_resp_ptr_nxt = r_resp_ptr + PTR_WIDTH'(w_resp_live);

   always_comb begin
      w_done_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_ent[i].state == DONE) w_done_cnt = w_done_cnt + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i]  <= '0;
            r_wreg[i] <= '0;
         end
         r_tail            <= '0;
         r_resp_ptr        <= '0;
         r_head            <= '0;
         r_count           <= '0;
         r_resp_unexpected <= 1'b0;
      end else begin
         // DONE at resp_ptr only happens with the ring full of finished entries
         r_resp_unexpected <= bus.resp_valid && !w_resp_live;
         if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_ent[i].state == DONE)         r_ent[i].state <= FREE;
               else if (r_ent[i].state == PENDING) r_ent[i].state <= DISCARD;
            end
            if (w_resp_live) r_ent[r_resp_ptr].state <= FREE;
            r_resp_ptr <= w_resp_ptr_nxt;
            r_head     <= w_resp_ptr_nxt;
            r_count    <= r_count - w_done_cnt - COUNT_WIDTH'(w_resp_live);
         end else begin
            if (w_alloc) begin
               r_ent[r_tail] <= '{state:       PENDING,
                                  is_store:    bus.req_is_store,
                                  kind:        bus.req_load_kind,
                                  is_unsigned: bus.req_unsigned,
                                  offset:      bus.req_address_low,
                                  data:        32'h0};
               r_wreg[r_tail] <= bus.req_write_register;
               r_tail         <= r_tail + PTR_WIDTH'(1);
            end
            if (w_resp_pend) begin
               r_ent[r_resp_ptr].state <= DONE;
               r_ent[r_resp_ptr].data  <= bus.resp_data;
            end
            // a DISCARD at resp_ptr implies head == resp_ptr, so it never collides with a retire
            if (w_resp_disc) r_ent[r_resp_ptr].state <= FREE;
            if (w_retire)    r_ent[r_head].state     <= FREE;
            if (w_retire || w_resp_disc) r_head <= r_head + PTR_WIDTH'(1);
            r_resp_ptr <= w_resp_ptr_nxt;
            r_count    <= r_count + COUNT_WIDTH'(w_alloc)
                          - COUNT_WIDTH'(w_retire) - COUNT_WIDTH'(w_resp_disc);
         end
      end
   end

   load_result_formatter u_formatter (
      .i_kind     (w_head.kind),
      .i_unsigned (w_head.is_unsigned),
      .i_offset   (w_head.offset),
      .i_data     (w_head.data),
      .o_result   (bus.out_data),
      .o_strobe   (bus.out_write_strobe)
   );

   assign bus.req_ready          = w_ready;
   assign bus.out_valid          = w_head_done && !w_head.is_store;
   assign bus.out_write_register = r_wreg[r_head];
   assign bus.outstanding_count  = r_count;
   assign bus.resp_unexpected    = r_resp_unexpected;

endmodule
`default_nettype wire

// File: tb/tb_io_load_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_load_tracker : directed plus random checks against a transaction-queue model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_io_load_tracker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   io_load_tracker_if #(.DEPTH(4), .REG_ADDR_WIDTH(5)) bus ();

   io_load_tracker #(.DEPTH(4), .REG_ADDR_WIDTH(5)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct {
      bit        st;
      bit [2:0]  kind;
      bit        uns;
      bit [1:0]  off;
      bit [4:0]  rg;
      bit [31:0] d;
      bit        disc;
   } txn_t;

   txn_t pend_q[$];
   txn_t done_q[$];
   bit   exp_unexp = 1'b0;
   int   n_assert  = 0;
   int   n_fail    = 0;
   int   n_out     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_fmt(input txn_t t, output bit [31:0] r, output bit [3:0] s);
      bit [31:0] b;
      r = t.d;
      s = 4'hF;
      case (t.kind)
         3'd0: begin
            b = (t.d >> (8 * int'(t.off))) & 32'hFF;
            r = (t.uns || b < 128) ? b : (b | 32'hFFFF_FF00);
         end
         3'd1: begin
            b = (t.off[1] ? (t.d >> 16) : t.d) & 32'hFFFF;
            r = (t.uns || b < 32768) ? b : (b | 32'hFFFF_0000);
         end
         3'd3: begin
            r = t.d << (8 * (3 - int'(t.off)));
            s = 4'((15 << (3 - int'(t.off))) & 15);
         end
         3'd4: begin
            r = t.d >> (8 * int'(t.off));
            s = 4'(15 >> int'(t.off));
         end
         default: ;
      endcase
   endfunction

   // Check visible outputs mid-cycle, then advance the model across the next edge.
   task automatic step();
      bit        exp_ready, exp_ov;
      bit [31:0] r;
      bit [3:0]  s;
      txn_t      t;
      @(negedge clk);
      exp_ready = (pend_q.size() + done_q.size() < 4) && !bus.flush;
      exp_ov    = !bus.flush && done_q.size() > 0 && !done_q[0].st;
      chk("count", 32'(bus.outstanding_count), 32'(pend_q.size() + done_q.size()));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("resp_unexpected", 32'(bus.resp_unexpected), 32'(exp_unexp));
      if (exp_ov) begin
         ref_fmt(done_q[0], r, s);
         chk("out_data", bus.out_data, r);
         chk("out_strobe", 32'(bus.out_write_strobe), 32'(s));
         chk("out_reg", 32'(bus.out_write_register), 32'(done_q[0].rg));
         if (bus.out_ready) n_out++;
      end
      exp_unexp = bus.resp_valid && pend_q.size() == 0;
      if (bus.flush) begin
         done_q.delete();
         if (bus.resp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
         foreach (pend_q[i]) pend_q[i].disc = 1'b1;
      end else begin
         if (done_q.size() > 0 && (done_q[0].st || bus.out_ready)) void'(done_q.pop_front());
         if (bus.resp_valid && pend_q.size() > 0) begin
            t = pend_q.pop_front();
            t.d = bus.resp_data;
            if (!t.disc) done_q.push_back(t);
         end
         if (bus.req_valid && exp_ready) begin
            t = '{st: bus.req_is_store, kind: bus.req_load_kind, uns: bus.req_unsigned,
                  off: bus.req_address_low, rg: bus.req_write_register, d: 32'h0, disc: 1'b0};
            pend_q.push_back(t);
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.flush      = 1'b0;
   endtask

   task automatic issue(input bit st, input bit [2:0] kind, input bit uns,
                        input bit [1:0] off, input bit [4:0] rg);
      bus.req_valid          = 1'b1;
      bus.req_is_store       = st;
      bus.req_load_kind      = kind;
      bus.req_unsigned       = uns;
      bus.req_address_low    = off;
      bus.req_write_register = rg;
   endtask

   task automatic respond(input bit [31:0] d);
      bus.resp_valid = 1'b1;
      bus.resp_data  = d;
   endtask

   initial begin
      bit [31:0] d;
      bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_load_kind = 3'd0;
      bus.req_unsigned = 1'b0; bus.req_address_low = 2'd0; bus.req_write_register = 5'd0;
      bus.resp_valid = 1'b0; bus.resp_data = 32'h0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();

      // single LW with one-cycle response latency
      bus.out_ready = 1'b1;
      issue(0, 3'd2, 0, 2'd0, 5'd1); step();
      respond(32'hDEADBEEF); step();
      chk("lw_valid", 32'(bus.out_valid), 32'd1);
      chk("lw_data", bus.out_data, 32'hDEADBEEF);
      chk("lw_strobe", 32'(bus.out_write_strobe), 32'hF);
      step();
      chk("lw_count_after", 32'(bus.outstanding_count), 32'd0);

      // LB sign / zero extension and LWL partial write
      issue(0, 3'd0, 0, 2'd3, 5'd2); step();
      respond({8'h80, 24'($urandom)}); step();
      chk("lb_signed", bus.out_data, 32'hFFFF_FF80);
      step();
      issue(0, 3'd0, 1, 2'd3, 5'd3); step();
      respond({8'h80, 24'($urandom)}); step();
      chk("lb_unsigned", bus.out_data, 32'h0000_0080);
      step();
      issue(0, 3'd3, 0, 2'd1, 5'd4); step();
      respond(32'h11223344); step();
      chk("lwl_data", bus.out_data, 32'h3344_0000);
      chk("lwl_strobe", 32'(bus.out_write_strobe), 32'hC);
      step();

      // fill the ring, hold results, then drain in order
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(0, 3'($urandom_range(0, 4)), 1'($urandom), 2'($urandom), 5'(10 + i));
         step();
      end
      chk("full_ready", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin respond($urandom); step(); end
      bus.out_ready = 1'b1;
      repeat (5) step();
      chk("drain_count", 32'(bus.outstanding_count), 32'd0);
      chk("drain_ready", 32'(bus.req_ready), 32'd1);

      // flush with one finished and two outstanding loads
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin issue(0, 3'd2, 0, 2'd0, 5'(20 + i)); step(); end
      respond($urandom); step();
      bus.flush = 1'b1; step();
      respond($urandom); step();
      respond($urandom); step();
      chk("flush_count", 32'(bus.outstanding_count), 32'd0);
      bus.out_ready = 1'b1;
      issue(0, 3'd2, 0, 2'd0, 5'd25); step();
      d = $urandom;
      respond(d); step();
      chk("post_flush_data", bus.out_data, d);
      step();

      // store produces no result; stray response flags unexpected
      n_out = 0;
      issue(1, 3'd2, 0, 2'd0, 5'd0); step();
      issue(0, 3'd2, 0, 2'd0, 5'd6); step();
      respond(32'h0); step();
      respond(32'h55); step();
      step();
      chk("store_load_outputs", 32'(n_out), 32'd1);
      respond($urandom); step();
      chk("unexp_pulse", 32'(bus.resp_unexpected), 32'd1);
      step();
      chk("unexp_clear", 32'(bus.resp_unexpected), 32'd0);

      // asynchronous reset with entries in flight
      bus.out_ready = 1'b0;
      issue(0, 3'd2, 0, 2'd0, 5'd7); step();
      issue(0, 3'd2, 0, 2'd0, 5'd8); respond($urandom); step();
      chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_count", 32'(bus.outstanding_count), 32'd0);
      chk("async_valid", 32'(bus.out_valid), 32'd0);
      chk("async_ready", 32'(bus.req_ready), 32'd1);
      pend_q.delete(); done_q.delete(); exp_unexp = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      respond($urandom); step();
      respond($urandom); step();
      step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 1) == 1)
            issue(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
                  2'($urandom), 5'($urandom));
         if ($urandom_range(0, 2) != 0) respond($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
